// File: rtl/traffic_pkg.sv
// Shared types for the two-road traffic light controller: phase encoding,
// lamp patterns and the phase-to-lamp decode used by the controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        FLASH       = 3'd6
    } phase_e;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef struct packed {
        logic [2:0] main_rgy;
        logic [2:0] side_rgy;
    } lamps_t;

    // Anything that is not an explicit go/caution phase shows red both ways.
    function automatic lamps_t phase_lamps(input phase_e p);
        lamps_t l;
        case (p)
            MAIN_GREEN:  l = '{main_rgy: LAMP_G, side_rgy: LAMP_R};
            MAIN_YELLOW: l = '{main_rgy: LAMP_Y, side_rgy: LAMP_R};
            SIDE_GREEN:  l = '{main_rgy: LAMP_R, side_rgy: LAMP_G};
            SIDE_YELLOW: l = '{main_rgy: LAMP_R, side_rgy: LAMP_Y};
            FLASH:       l = '{main_rgy: LAMP_Y, side_rgy: LAMP_R};
            default:     l = '{main_rgy: LAMP_R, side_rgy: LAMP_R};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable down-counter holding the ticks left in the current phase.
// expire flags the tick that consumes the last remaining tick.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 6,
    parameter int RESET_VAL = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] remain,
    output logic             expire
);

    logic [CNT_W-1:0] r_remain;

    // Load has priority so a phase change always starts from a full duration.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_remain <= CNT_W'(RESET_VAL);
        end else if (load) begin
            r_remain <= load_val;
        end else if (tick && (r_remain != '0)) begin
            r_remain <= r_remain - 1'b1;
        end
    end

    assign remain = r_remain;
    assign expire = tick && (r_remain == CNT_W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Main/side intersection controller with pedestrian request, driven by a 1 Hz tick.
// Optional night flashing mode is built when TRAFFIC_NIGHT_FLASH_EN is defined.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int T_MAIN_GREEN = 20,
    parameter int T_MAIN_MIN   = 5,
    parameter int T_SIDE_GREEN = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             night,
    output logic [2:0]       main_rgy,
    output logic [2:0]       side_rgy,
    output logic             walk,
    output logic             ped_ack,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase
);

    // A pending request may end main green once this many ticks or fewer remain.
    localparam logic [CNT_W-1:0] CUT_TH = CNT_W'(T_MAIN_GREEN - T_MAIN_MIN + 1);

    phase_e           r_state;
    phase_e           w_next_state;
    logic             r_ped_pending;
    logic             w_ped_pending_nxt;
    lamps_t           r_lamps;
    lamps_t           w_lamps_nxt;
    logic             r_walk;
    logic             w_walk_nxt;
    logic             r_ped_ack;
    logic             w_ped_ack_nxt;
    logic             w_enter_side;
    logic             w_early;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_remain;
    logic             w_expire;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic             r_flash_lit;
    logic             w_flash_lit_nxt;
`else
    logic             w_unused_night;
    assign w_unused_night = night;
`endif

    function automatic logic [CNT_W-1:0] phase_duration(input phase_e p);
        logic [CNT_W-1:0] d;
        case (p)
            MAIN_GREEN:  d = CNT_W'(T_MAIN_GREEN);
            MAIN_YELLOW: d = CNT_W'(T_YELLOW);
            ALL_RED_A:   d = CNT_W'(T_ALL_RED);
            SIDE_GREEN:  d = CNT_W'(T_SIDE_GREEN);
            SIDE_YELLOW: d = CNT_W'(T_YELLOW);
            ALL_RED_B:   d = CNT_W'(T_ALL_RED);
            default:     d = '0;
        endcase
        return d;
    endfunction

    traffic_phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (T_MAIN_GREEN)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick),
        .remain   (w_remain),
        .expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= MAIN_GREEN;
            r_ped_pending <= 1'b0;
            r_lamps       <= phase_lamps(MAIN_GREEN);
            r_walk        <= 1'b0;
            r_ped_ack     <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            r_flash_lit   <= 1'b1;
`endif
        end else begin
            r_state       <= w_next_state;
            r_ped_pending <= w_ped_pending_nxt;
            r_lamps       <= w_lamps_nxt;
            r_walk        <= w_walk_nxt;
            r_ped_ack     <= w_ped_ack_nxt;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            r_flash_lit   <= w_flash_lit_nxt;
`endif
        end
    end

    assign w_early = (r_state == MAIN_GREEN) && r_ped_pending && (w_remain <= CUT_TH);

    // An unreachable encoding drops straight into the all-red clearance.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MAIN_GREEN:  if (w_expire || (tick && w_early)) w_next_state = MAIN_YELLOW;
            MAIN_YELLOW: if (w_expire) w_next_state = ALL_RED_A;
            ALL_RED_A:   if (w_expire) w_next_state = SIDE_GREEN;
            SIDE_GREEN:  if (w_expire) w_next_state = SIDE_YELLOW;
            SIDE_YELLOW: if (w_expire) w_next_state = ALL_RED_B;
            ALL_RED_B:   if (w_expire) w_next_state = MAIN_GREEN;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH:       if (tick && !night) w_next_state = ALL_RED_B;
`endif
            default:     w_next_state = ALL_RED_B;
        endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (tick && night) w_next_state = FLASH;
`endif
        w_load     = (w_next_state != r_state);
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if ((r_state == FLASH) && tick) w_load = 1'b1;
`endif
        w_load_val = phase_duration(w_next_state);
    end

    // Walk is decided once on side-green entry and then held for the phase.
    always_comb begin
        w_enter_side      = (w_next_state == SIDE_GREEN) && (r_state != SIDE_GREEN);
        w_lamps_nxt       = phase_lamps(w_next_state);
        w_walk_nxt        = (w_next_state == SIDE_GREEN) && (w_enter_side ? r_ped_pending : r_walk);
        w_ped_ack_nxt     = w_enter_side && r_ped_pending;
        w_ped_pending_nxt = ped_req | (r_ped_pending & ~w_enter_side);
`ifdef TRAFFIC_NIGHT_FLASH_EN
        w_flash_lit_nxt = 1'b1;
        if (r_state == FLASH) begin
            w_flash_lit_nxt   = tick ? ~r_flash_lit : r_flash_lit;
            w_ped_pending_nxt = 1'b0;
        end
        if (w_next_state == FLASH) begin
            w_ped_pending_nxt = 1'b0;
            if (!w_flash_lit_nxt) w_lamps_nxt = '{main_rgy: LAMP_OFF, side_rgy: LAMP_OFF};
        end
`endif
    end

    assign main_rgy = r_lamps.main_rgy;
    assign side_rgy = r_lamps.side_rgy;
    assign walk     = r_walk;
    assign ped_ack  = r_ped_ack;
    assign remain   = w_remain;
    assign phase    = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: vector table, hand sequences,
// and randomized traffic against a phase/elapsed-tick reference model.
module tb_traffic_light_ctrl;

    localparam int CNT_W = 6;
    localparam int T_MG  = 20;
    localparam int T_MIN = 5;
    localparam int T_SG  = 10;
    localparam int T_Y   = 3;
    localparam int T_AR  = 1;

    logic clk = 1'b0;
    logic rstn = 1'b0, tick = 1'b0, pedReq = 1'b0, night = 1'b0;
    logic [2:0] mainRgy, sideRgy, phase;
    logic walk, pedAck;
    logic [CNT_W-1:0] remain;

    logic rstn2 = 1'b0, tick2 = 1'b0, ped2 = 1'b0, night2 = 1'b0;
    logic [2:0] mainRgy2, sideRgy2, phase2;
    logic walk2, pedAck2;
    logic [CNT_W-1:0] remain2;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk(clk), .rstn(rstn), .tick(tick), .ped_req(pedReq), .night(night),
        .main_rgy(mainRgy), .side_rgy(sideRgy), .walk(walk), .ped_ack(pedAck),
        .remain(remain), .phase(phase)
    );

    traffic_light_ctrl #(.T_MAIN_GREEN(5), .T_MAIN_MIN(5)) dutShort (
        .clk(clk), .rstn(rstn2), .tick(tick2), .ped_req(ped2), .night(night2),
        .main_rgy(mainRgy2), .side_rgy(sideRgy2), .walk(walk2), .ped_ack(pedAck2),
        .remain(remain2), .phase(phase2)
    );

    int vectors = 0;
    int miscompares = 0;

    int         dur[6]     = '{T_MG, T_Y, T_AR, T_SG, T_Y, T_AR};
    logic [2:0] expMain[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] expSide[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int mPhase = 0, mElapsed = 0;
    bit mPend = 0, mWalk = 0, mAck = 0;

    typedef struct {
        bit rstn; bit tick; bit ped;
        int phase; int remain; bit walk; bit ack;
    } vec_t;
    vec_t vecs[14];

    task automatic cmp(input string tag, input string field, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got %0d, expected %0d", tag, field, act, exp);
        end
    endtask

    // Reference: phase index plus ticks spent in it; a phase ends after dur ticks,
    // or main green ends early once a pending request sees remain <= T_MG-T_MIN+1.
    task automatic modelStep(input bit r, input bit t, input bit p);
        bit wasPend;
        bit adv;
        int rem;
        if (!r) begin
            mPhase = 0; mElapsed = 0; mPend = 0; mWalk = 0; mAck = 0;
        end else begin
            wasPend = mPend;
            adv = 0;
            mAck = 0;
            if (t) begin
                rem = dur[mPhase] - mElapsed;
                if (rem == 1) adv = 1;
                else if (mPhase == 0 && mPend && rem <= T_MG - T_MIN + 1) adv = 1;
                if (adv) begin
                    mPhase = (mPhase + 1) % 6;
                    mElapsed = 0;
                    if (mPhase == 3) begin
                        mWalk = wasPend; mAck = wasPend; mPend = 0;
                    end else begin
                        mWalk = 0;
                    end
                end else begin
                    mElapsed++;
                end
            end
            if (p) mPend = 1;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit t, input bit p, input bit n);
        rstn = r; tick = t; pedReq = p; night = n;
        @(posedge clk);
        #1;
        modelStep(r, t, p);
    endtask

    task automatic checkOutput(input string tag);
        vectors++;
        cmp(tag, "phase", int'(phase), mPhase);
        cmp(tag, "remain", int'(remain), dur[mPhase] - mElapsed);
        cmp(tag, "main_rgy", int'(mainRgy), int'(expMain[mPhase]));
        cmp(tag, "side_rgy", int'(sideRgy), int'(expSide[mPhase]));
        cmp(tag, "walk", int'(walk), int'(mWalk));
        cmp(tag, "ped_ack", int'(pedAck), int'(mAck));
        cmp(tag, "bothNonRed", int'(mainRgy != 3'b100 && sideRgy != 3'b100), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        int walkTicks;
        int ackCnt;
        bit seenWalk;

        vecs[0]  = '{0, 0, 0, 0, 20, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 19, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 19, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 18, 0, 0};
        vecs[4]  = '{1, 0, 1, 0, 18, 0, 0};
        vecs[5]  = '{1, 1, 0, 0, 17, 0, 0};
        vecs[6]  = '{1, 1, 0, 0, 16, 0, 0};
        vecs[7]  = '{1, 1, 0, 1, 3, 0, 0};
        vecs[8]  = '{1, 1, 0, 1, 2, 0, 0};
        vecs[9]  = '{1, 1, 0, 1, 1, 0, 0};
        vecs[10] = '{1, 1, 0, 2, 1, 0, 0};
        vecs[11] = '{1, 1, 0, 3, 10, 1, 1};
        vecs[12] = '{1, 0, 0, 3, 10, 1, 0};
        vecs[13] = '{0, 0, 0, 0, 20, 0, 0};

        $display("[TB] table vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].tick, vecs[i].ped, 1'b0);
            vectors++;
            cmp($sformatf("vec%0d", i), "phase", int'(phase), vecs[i].phase);
            cmp($sformatf("vec%0d", i), "remain", int'(remain), vecs[i].remain);
            cmp($sformatf("vec%0d", i), "main_rgy", int'(mainRgy), int'(expMain[vecs[i].phase]));
            cmp($sformatf("vec%0d", i), "side_rgy", int'(sideRgy), int'(expSide[vecs[i].phase]));
            cmp($sformatf("vec%0d", i), "walk", int'(walk), int'(vecs[i].walk));
            cmp($sformatf("vec%0d", i), "ped_ack", int'(pedAck), int'(vecs[i].ack));
        end

        $display("[TB] full cycle without requests");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        seenWalk = 0;
        for (int i = 0; i < 38; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("cycle38");
            if (walk) seenWalk = 1;
        end
        vectors++;
        cmp("cycle38End", "phase", int'(phase), 0);
        cmp("cycle38End", "remain", int'(remain), 20);
        cmp("cycle38End", "walkSeen", int'(seenWalk), 0);

        $display("[TB] early cut by pedestrian pulse");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pedPulse");
        cnt = 2;
        for (int i = 0; i < 30 && phase == 3'd0; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("pedCut");
            cnt++;
        end
        vectors++;
        cmp("pedCut", "mainGreenTicks", cnt, 5);
        walkTicks = 0;
        ackCnt = 0;
        for (int i = 0; i < 40 && !(phase == 3'd0 && walkTicks > 0); i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("pedWalk");
            if (walk) walkTicks++;
            if (pedAck) ackCnt++;
        end
        vectors++;
        cmp("pedWalk", "walkTicks", walkTicks, 10);
        cmp("pedWalk", "ackPulses", ackCnt, 1);

        $display("[TB] request held across side-green entry");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && phase != 3'd3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput("heldReq");
        end
        vectors++;
        cmp("heldReq", "ackAtEntry", int'(pedAck), 1);
        for (int i = 0; i < 40 && phase != 3'd0; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("heldReqSide");
        end
        cnt = 0;
        for (int i = 0; i < 30 && phase == 3'd0; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("heldReqNext");
            cnt++;
        end
        vectors++;
        cmp("heldReqNext", "mainGreenTicks", cnt, 5);

        $display("[TB] idle without ticks, then reset mid side green");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("idle");
        end
        vectors++;
        cmp("idle", "remain", int'(remain), 13);
        for (int i = 0; i < 80 && !(phase == 3'd3 && remain == 7); i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        vectors++;
        cmp("midSide", "phase", int'(phase), 3);
        cmp("midSide", "remain", int'(remain), 7);
        cmp("midSide", "walk", int'(walk), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        cmp("midReset", "phase", int'(phase), 0);
        cmp("midReset", "remain", int'(remain), 20);
        cmp("midReset", "walk", int'(walk), 0);
        cmp("midReset", "main_rgy", int'(mainRgy), 1);

        $display("[TB] short main green, no early cut");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rstn2 = 1'b0;
        @(posedge clk); #1;
        rstn2 = 1'b1; ped2 = 1'b1;
        @(posedge clk); #1;
        ped2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick2 = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (i < 5) begin
                cmp($sformatf("short%0d", i), "phase", int'(phase2), 0);
                cmp($sformatf("short%0d", i), "remain", int'(remain2), 5 - i);
            end else begin
                cmp("short5", "phase", int'(phase2), 1);
                cmp("short5", "remain", int'(remain2), 3);
                cmp("short5", "main_rgy", int'(mainRgy2), 2);
            end
        end
        tick2 = 1'b0;

`ifdef TRAFFIC_NIGHT_FLASH_EN
        $display("[TB] night flash");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && phase != 3'd3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        cmp("flashIn", "phase", int'(phase), 6);
        cmp("flashIn", "main_rgy", int'(mainRgy), 2);
        cmp("flashIn", "side_rgy", int'(sideRgy), 4);
        cmp("flashIn", "remain", int'(remain), 0);
        cmp("flashIn", "walk", int'(walk), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        cmp("flashHold", "main_rgy", int'(mainRgy), 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        cmp("flashOff", "main_rgy", int'(mainRgy), 0);
        cmp("flashOff", "side_rgy", int'(sideRgy), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        vectors++;
        cmp("flashOn", "main_rgy", int'(mainRgy), 2);
        cmp("flashOn", "side_rgy", int'(sideRgy), 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        cmp("flashExit", "phase", int'(phase), 5);
        cmp("flashExit", "remain", int'(remain), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        cmp("flashMain", "phase", int'(phase), 0);
        cmp("flashMain", "remain", int'(remain), 20);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        cmp("flashNoPend", "phase", int'(phase), 0);
        cmp("flashNoPend", "remain", int'(remain), 15);
`endif

        $display("[TB] randomized traffic");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            bit r, t, p, n;
            r = ($urandom_range(0, 399) != 0);
            t = ($urandom_range(0, 2) == 0);
            p = ($urandom_range(0, 24) == 0);
`ifdef TRAFFIC_NIGHT_FLASH_EN
            n = 1'b0;
`else
            n = 1'(($urandom_range(0, 1)));
`endif
            applyStimulus(r, t, p, n);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
